// File: rtl/twos_abs_pipe.sv
// Two-stage valid/ready pipeline: pass / negate / absolute / sign-magnitude with MIN saturation.
// Define OVF_COUNT_EN to add the saturating ovf_count output.
module twos_abs_pipe #(
  parameter int B     = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B-1:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [B-1:0]     out_data,
  output logic             out_ovf,
  output logic             out_sign
`ifdef OVF_COUNT_EN
  ,
  output logic [CNT_W-1:0] ovf_count
`endif
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_SM   = 2'b11
  } mode_e;

  localparam logic [B-1:0] MIN_V = {1'b1, {(B-1){1'b0}}};
  localparam logic [B-1:0] MAX_V = {1'b0, {(B-1){1'b1}}};
  localparam logic [B-1:0] ONE_V = {{(B-1){1'b0}}, 1'b1};

  generate
    if (B < 2 || CNT_W < 1) begin : g_bad_param
      $error("twos_abs_pipe: B must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  logic         s1_valid;
  logic [B-1:0] s1_data;
  mode_e        s1_mode;
  logic         s2_valid;
  logic         s1_adv;
  logic         s2_adv;

  logic [B-1:0] neg;
  logic         is_min;
  logic         is_neg;
  logic [B-1:0] res;
  logic         res_ovf;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= mode_e'(in_mode);
      end
    end
  end

  always_comb begin
    neg     = ~s1_data + ONE_V;
    is_min  = (s1_data == MIN_V);
    is_neg  = s1_data[B-1];
    res     = s1_data;
    res_ovf = 1'b0;
    case (s1_mode)
      MODE_PASS: begin
        res     = s1_data;
        res_ovf = 1'b0;
      end
      MODE_NEG: begin
        res     = is_min ? MAX_V : neg;
        res_ovf = is_min;
      end
      MODE_ABS: begin
        res     = !is_neg ? s1_data : (is_min ? MAX_V : neg);
        res_ovf = is_min;
      end
      MODE_SM: begin
        // Negative values carry the sign in the MSB over the two's-complement magnitude.
        if (is_min)      res = '1;
        else if (is_neg) res = {1'b1, neg[B-2:0]};
        else             res = s1_data;
        res_ovf = is_min;
      end
      default: begin
        res     = s1_data;
        res_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_sign <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_ovf  <= res_ovf;
        out_sign <= is_neg;
      end
    end
  end

`ifdef OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (s2_valid && out_ready && out_ovf && (ovf_count != '1)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_twos_abs_pipe.sv
// Directed self-checking bench for twos_abs_pipe (B=12); ovf_count checks compile in with OVF_COUNT_EN.
module tb_twos_abs_pipe;

  localparam int B = 12;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [B-1:0] out_data;
  logic         out_ovf;
  logic         out_sign;
`ifdef OVF_COUNT_EN
  logic [15:0]  ovf_count;
`endif

  int checks   = 0;
  int failures = 0;

  twos_abs_pipe #(.B(B), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_sign  (out_sign)
`ifdef OVF_COUNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change at a negedge; the next posedge consumes them; outputs are read at the following negedge.
  task automatic step(input logic v, input logic [B-1:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b0, '0, 2'b00, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 12'h000) begin failures++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    checks++; if (out_sign !== 1'b0) begin failures++; $display("FAIL reset_out_sign got=%b exp=0", out_sign); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef OVF_COUNT_EN
    checks++; if (ovf_count !== 16'd0) begin failures++; $display("FAIL reset_ovf_count got=%0d exp=0", ovf_count); end
`endif
  endtask

  task automatic test_abs_stream;
    logic [B-1:0] exp_d [0:2];
    logic         exp_s [0:2];
    exp_d = '{12'h00C, 12'h053, 12'h000};
    exp_s = '{1'b0, 1'b1, 1'b0};
    step(1'b1, 12'h00C, 2'b10, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abs_latency_early got=%b exp=0", out_valid); end
    step(1'b1, 12'hFAD, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abs_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp_d[i]) begin failures++; $display("FAIL abs_data[%0d] got=%h exp=%h", i, out_data, exp_d[i]); end
      checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL abs_ovf[%0d] got=%b exp=0", i, out_ovf); end
      checks++; if (out_sign !== exp_s[i]) begin failures++; $display("FAIL abs_sign[%0d] got=%b exp=%b", i, out_sign, exp_s[i]); end
      if (i == 0) step(1'b1, 12'h000, 2'b10, 1'b1);
      else        step(1'b0, 12'h000, 2'b00, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abs_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_ops;
    logic [1:0]   vm [0:14];
    logic [B-1:0] vi [0:14];
    logic [B-1:0] vo [0:14];
    logic         vv [0:14];
    logic         vs [0:14];
    vm = '{2'd1,    2'd0,    2'd1,    2'd2,    2'd3,    2'd0,    2'd3,    2'd3,
           2'd3,    2'd1,    2'd2,    2'd1,    2'd3,    2'd2,    2'd1};
    vi = '{12'h4EF, 12'hFA6, 12'h800, 12'h800, 12'h800, 12'h800, 12'hFA6, 12'h4B1,
           12'h000, 12'h000, 12'h7FF, 12'h7FF, 12'hFFF, 12'h801, 12'hFFF};
    vo = '{12'hB11, 12'hFA6, 12'h7FF, 12'h7FF, 12'hFFF, 12'h800, 12'h85A, 12'h4B1,
           12'h000, 12'h000, 12'h7FF, 12'h801, 12'h801, 12'h7FF, 12'h001};
    vv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 15; i++) begin
      step(1'b1, vi[i], vm[i], 1'b1);
      step(1'b0, '0, 2'b00, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL op_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== vo[i]) begin failures++; $display("FAIL op_data[%0d] mode=%0d in=%h got=%h exp=%h", i, vm[i], vi[i], out_data, vo[i]); end
      checks++; if (out_ovf !== vv[i]) begin failures++; $display("FAIL op_ovf[%0d] got=%b exp=%b", i, out_ovf, vv[i]); end
      checks++; if (out_sign !== vs[i]) begin failures++; $display("FAIL op_sign[%0d] got=%b exp=%b", i, out_sign, vs[i]); end
    end
    step(1'b0, '0, 2'b00, 1'b1);
  endtask

  task automatic test_mode_switch;
    logic [1:0]   vm [0:3];
    logic [B-1:0] vi [0:3];
    logic [B-1:0] vo [0:3];
    logic         vv [0:3];
    vm = '{2'd0, 2'd1, 2'd2, 2'd3};
    vi = '{12'h800, 12'h800, 12'hFFF, 12'hFFF};
    vo = '{12'h800, 12'h7FF, 12'h001, 12'h801};
    vv = '{1'b0, 1'b1, 1'b0, 1'b0};
    step(1'b1, vi[0], vm[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b1, vi[i+1], vm[i+1], 1'b1);
      else       step(1'b0, '0, 2'b00, 1'b1);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sw_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== vo[i]) begin failures++; $display("FAIL sw_data[%0d] got=%h exp=%h", i, out_data, vo[i]); end
      checks++; if (out_ovf !== vv[i]) begin failures++; $display("FAIL sw_ovf[%0d] got=%b exp=%b", i, out_ovf, vv[i]); end
    end
    step(1'b0, '0, 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sw_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [B-1:0] src [0:3];
    logic [B-1:0] exp_o [0:3];
    int idx  = 0;
    int oidx = 0;
    src   = '{12'hFFF, 12'h002, 12'hFFD, 12'h004};
    exp_o = '{12'h001, 12'h002, 12'h003, 12'h004};
    for (int c = 0; c < 16 && oidx < 4; c++) begin
      in_valid  = (idx < 4);
      in_data   = (idx < 4) ? src[idx] : '0;
      in_mode   = 2'b10;
      out_ready = (c >= 4);
      #1;
      if (c < 4) begin
        checks++; if (in_ready !== (c < 2)) begin failures++; $display("FAIL bp_in_ready[c%0d] got=%b exp=%b", c, in_ready, (c < 2)); end
      end
      if (c == 2 || c == 3) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 12'h001) begin failures++; $display("FAIL bp_hold[c%0d] got=%b/%h exp=1/001", c, out_valid, out_data); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        checks++; if (out_data !== exp_o[oidx]) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", oidx, out_data, exp_o[oidx]); end
        oidx++;
      end
      @(negedge clk);
    end
    checks++; if (idx != 4 || oidx != 4) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=4/4", idx, oidx); end
    step(1'b0, '0, 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream;
    step(1'b1, 12'h800, 2'b01, 1'b0);
    step(1'b1, 12'hFA6, 2'b11, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_ovf !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%b/%b exp=1/1", out_valid, out_ovf); end
    rst = 1'b1;
    step(1'b0, '0, 2'b00, 1'b1);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 12'h000) begin failures++; $display("FAIL mid_data got=%h exp=000", out_data); end
    checks++; if (out_ovf !== 1'b0 || out_sign !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b/%b exp=0/0", out_ovf, out_sign); end
    step(1'b0, '0, 2'b00, 1'b1);
    step(1'b0, '0, 2'b00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_partial got=%b exp=0", out_valid); end
  endtask

`ifdef OVF_COUNT_EN
  task automatic test_ovf_count;
    step(1'b1, 12'h800, 2'b10, 1'b1);
    step(1'b1, 12'h800, 2'b10, 1'b1);
    step(1'b1, 12'h005, 2'b10, 1'b1);
    step(1'b1, 12'h800, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 2'b00, 1'b1);
    checks++; if (ovf_count !== 16'd3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", ovf_count); end
    rst = 1'b1;
    step(1'b0, '0, 2'b00, 1'b1);
    rst = 1'b0;
    checks++; if (ovf_count !== 16'd0) begin failures++; $display("FAIL ovf_count_rst got=%0d exp=0", ovf_count); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_abs_stream;
    test_ops;
    test_mode_switch;
    test_backpressure;
    test_reset_midstream;
`ifdef OVF_COUNT_EN
    test_ovf_count;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
